// File: rtl/alu_issue_stage.sv
// Issue/writeback wrapper around a combinational 32-bit alu.
// Requests are decoded on entry and buffered in a small FIFO. An issue
// register (E) drives the alu, and an output register (R) captures the result
// behind a valid/ready handshake. Sustains one op per clock.
module alu_issue_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = 5 + 2 * WIDTH;

  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push, pop, f_nonempty;
  logic [3:0]       head_ctrl;
  logic             head_ill;
  logic [WIDTH-1:0] head_src1, head_src2;
  logic             e_valid, e_ill;
  logic             r_fire, out_fire;

  // Decode request into the alu control code; unknown encodings flag illegal
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_ill  = 1'b0;
    case (in_aluop)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        case (in_funct)
          6'h20:   dec_ctrl = 4'b0010;
          6'h22:   dec_ctrl = 4'b0110;
          6'h24:   dec_ctrl = 4'b0000;
          6'h25:   dec_ctrl = 4'b0001;
          6'h27:   dec_ctrl = 4'b1100;
          6'h2A:   dec_ctrl = 4'b0111;
          6'h2E:   dec_ctrl = 4'b1101;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Handshake and stage-advance conditions
  always_comb begin
    in_ready   = (occ != OCC_W'(FIFO_DEPTH));
    f_nonempty = (occ != '0);
    push       = in_valid & in_ready;
    r_fire     = e_valid & (~out_valid | out_ready);
    pop        = f_nonempty & (~e_valid | r_fire);
    out_fire   = out_valid & out_ready;
    {head_ctrl, head_ill, head_src1, head_src2} = mem[rd_ptr];
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dec_ctrl, dec_ill, in_src1, in_src2};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Issue register: drives the alu; operands hold when the stage drains
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid  <= 1'b0;
      e_ill    <= 1'b0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= 4'b0000;
    end else if (pop) begin
      e_valid  <= 1'b1;
      e_ill    <= head_ill;
      alu_src1 <= head_src1;
      alu_src2 <= head_src2;
      alu_ctrl <= head_ctrl;
    end else if (r_fire) begin
      e_valid <= 1'b0;
    end
  end

  // Output register: captures alu returns; illegal ops report all zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_cout    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (r_fire) begin
      out_valid   <= 1'b1;
      out_result  <= e_ill ? '0 : alu_result;
      out_zero    <= ~e_ill & alu_zero;
      out_cout    <= ~e_ill & alu_cout;
      out_ovf     <= ~e_ill & alu_ovf;
      out_illegal <= e_ill;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-op and illegal-op counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt  <= '0;
      ill_cnt <= '0;
    end else if (out_fire) begin
      op_cnt <= op_cnt + CNT_W'(1);
      if (out_illegal) ill_cnt <= ill_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural alu closes the loop,
// and a scoreboard queue holds expected results in acceptance order.
module tb_alu_issue_stage;
  localparam int W  = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic         ill;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_aluop = '0;
  logic [5:0]    in_funct = '0;
  logic [W-1:0]  in_src1 = '0;
  logic [W-1:0]  in_src2 = '0;
  logic [W-1:0]  alu_src1, alu_src2;
  logic [3:0]    alu_ctrl;
  res_t          alu_o;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic          out_zero, out_cout, out_ovf, out_illegal;
  logic [CW-1:0] op_cnt, ill_cnt;

  res_t sb[$];
  res_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_ill    = 0;
  int   n_acc    = 0;
  bit   done5    = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(W), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct    (in_funct),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_o.res),
    .alu_zero    (alu_o.z),
    .alu_cout    (alu_o.c),
    .alu_ovf     (alu_o.v),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_cout    (out_cout),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal),
    .op_cnt      (op_cnt),
    .ill_cnt     (ill_cnt)
  );

  // Behavioural 32-bit alu
  function automatic res_t alu_fn(input logic [3:0] ctrl, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    res_t r;
    logic [W:0] s;
    r = '0;
    case (ctrl)
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0]; r.c = s[W];
        r.v = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.res = s[W-1:0]; r.c = s[W];
        r.v = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b1100: r.res = ~(a | b);
      4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1101: r.res = ~(a & b);
      default: r.res = '0;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  // Reference for a whole request: decode, then alu, with illegal ops zeroed
  function automatic res_t ref_fn(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [3:0] c;
    logic bad;
    bad = 1'b0;
    c = 4'b0000;
    if (op == 2'b00) c = 4'b0010;
    else if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11) bad = 1'b1;
    else if (f == 6'h20) c = 4'b0010;
    else if (f == 6'h22) c = 4'b0110;
    else if (f == 6'h24) c = 4'b0000;
    else if (f == 6'h25) c = 4'b0001;
    else if (f == 6'h27) c = 4'b1100;
    else if (f == 6'h2A) c = 4'b0111;
    else if (f == 6'h2E) c = 4'b1101;
    else bad = 1'b1;
    if (bad) begin
      r = '0;
      r.ill = 1'b1;
    end else begin
      r = alu_fn(c, a, b);
    end
    return r;
  endfunction

  always_comb alu_o = alu_fn(alu_ctrl, alu_src1, alu_src2);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the handshake edge
  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    bit acc;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_aluop = op;
    in_funct = f;
    in_src1  = a;
    in_src2  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick();
    check_eq("drain_done", 64'(sb.size() != 0 || out_valid), 64'd0);
    check_eq("op_cnt", op_cnt, n_out);
    check_eq("ill_cnt", ill_cnt, n_ill);
  endtask

  // Scoreboard: pop/compare on output handshakes, push on input handshakes
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      n_out = 0;
      n_ill = 0;
      n_acc = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("out_result", out_result, e.res);
          check_eq("out_flags", {out_illegal, out_zero, out_cout, out_ovf},
                   {e.ill, e.z, e.c, e.v});
          if (e.ill) n_ill++;
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_fn(in_aluop, in_funct, in_src1, in_src2));
        n_acc++;
      end
    end
  end

  initial begin
    int acc_cnt;
    bit acc;
    logic [5:0] fsel [8];
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24; fsel[3] = 6'h25;
    fsel[4] = 6'h27; fsel[5] = 6'h2A; fsel[6] = 6'h2E; fsel[7] = 6'h3F;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_alu_src1", alu_src1, 0);
    check_eq("rst_alu_ctrl", alu_ctrl, 0);
    check_eq("rst_op_cnt", op_cnt, 0);
    check_eq("rst_ill_cnt", ill_cnt, 0);

    // 1: AND with latency check
    out_ready = 1'b1;
    send(2'b10, 6'h24, 32'hffff0000, 32'h0000ffff);
    check_eq("lat_e0_out_valid", out_valid, 0);
    tick();
    check_eq("lat_e1_out_valid", out_valid, 0);
    check_eq("lat_e1_alu_src1", alu_src1, 32'hffff0000);
    tick();
    check_eq("lat_e2_out_valid", out_valid, 1);
    check_eq("t1_result", out_result, 0);
    check_eq("t1_flags", {out_zero, out_cout, out_ovf}, 3'b100);
    tick();
    check_eq("t1_op_cnt", op_cnt, 1);

    // 2: add carry-out, sub
    send(2'b00, 6'h00, 32'hffffffff, 32'h00000001);
    send(2'b01, 6'h00, 32'h7eda5023, 32'h2ec36ae5);
    drain();

    // 3: SLT and an illegal funct
    send(2'b10, 6'h2A, 32'hffffffff, 32'h00000001);
    send(2'b10, 6'h3F, 32'h12345678, 32'h9abcdef0);
    send(2'b11, 6'h20, 32'h1, 32'h1);
    drain();
    check_eq("t3_ill_cnt", ill_cnt, 2);

    // 4: backpressure fills R, E, then the FIFO
    out_ready = 1'b0;
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_aluop = 2'b00;
      in_src1  = 32'(acc_cnt * 3 + 1);
      in_src2  = 32'(acc_cnt + 100);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", 64'(acc_cnt), 64'd6);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_stream_valid", out_valid, 1);
      tick();
    end
    check_eq("bp_end_valid", out_valid, 0);
    check_eq("bp_end_in_ready", in_ready, 1);
    drain();

    // 5: continuous push with toggling out_ready
    done5 = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(2'($urandom_range(0, 3)), fsel[$urandom_range(0, 7)], $urandom, $urandom);
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          out_ready = ~out_ready;
          tick();
        end
      end
    join
    drain();
    check_eq("t5_no_loss", 64'(n_out), 64'(n_acc));

    // 6: reset with ops in flight
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd5, 32'd6);
    send(2'b01, 6'h00, 32'd9, 32'd2);
    send(2'b10, 6'h3F, 32'd1, 32'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    in_aluop = 2'b00;
    in_src1  = 32'd77;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check_eq("rst2_out_valid", out_valid, 0);
    check_eq("rst2_in_ready", in_ready, 1);
    check_eq("rst2_op_cnt", op_cnt, 0);
    check_eq("rst2_ill_cnt", ill_cnt, 0);
    check_eq("rst2_alu_ctrl", alu_ctrl, 0);
    check_eq("rst2_alu_src2", alu_src2, 0);
    check_eq("rst2_out_result", out_result, 0);
    tick();
    check_eq("rst2_not_accepted", out_valid, 0);
    out_ready = 1'b1;
    send(2'b00, 6'h00, 32'h7fffffff, 32'h00000001);
    tick();
    check_eq("rst2_lat_e1", out_valid, 0);
    tick();
    check_eq("rst2_lat_e2", out_valid, 1);
    check_eq("rst2_ovf", {out_zero, out_cout, out_ovf}, 3'b001);
    drain();
    check_eq("rst2_final_op_cnt", op_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
